// File: rtl/serial_index_select_pkg.sv
// ----------------------------------------------------------------------------
// serial_index_select_pkg
//   Shared constants for the serial index-select block and its frame position
//   tracker.
//   - ST_IDLE/ST_ARM/ST_SCAN/ST_HOLD : 2-bit FSM state encoding
//   - pos_limit()                    : saturation limit of the position counter
//                                      (2**index_width)
// ----------------------------------------------------------------------------
package serial_index_select_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a request
   localparam logic [1:0] ST_ARM  = 2'd1;  // request latched, waiting for frame start
   localparam logic [1:0] ST_SCAN = 2'd2;  // walking the scanned frame
   localparam logic [1:0] ST_HOLD = 2'd3;  // result presented, waiting for out_ready

   // One past the highest addressable position. The counter parks here for
   // overlong frames, so it can never equal a stored INDEX_WIDTH-bit index.
   function automatic int pos_limit(input int index_width);
      return 1 << index_width;
   endfunction

endpackage

// File: rtl/serial_frame_position.sv
// ----------------------------------------------------------------------------
// serial_frame_position
//   Tracks the position of the current element inside a valid/last framed
//   stream. pos is the index of the element presented this cycle; it counts
//   up on every in_valid, saturates at 2**INDEX_WIDTH and returns to 0 after
//   an in_last element. frame_start is 1 when the next valid element is the
//   first element of a frame.
//   Ports:
//     clk, rst     : clock, async active-low reset
//     in_valid     : stream element present this cycle
//     in_last      : current element closes its frame
//     pos          : position of the current element (INDEX_WIDTH+1 bits)
//     frame_start  : next/current element opens a new frame
// ----------------------------------------------------------------------------
module serial_frame_position
   import serial_index_select_pkg::*;
#(
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic [INDEX_WIDTH:0]   pos,
   output logic                   frame_start
);

   localparam logic [INDEX_WIDTH:0] LIMIT = (INDEX_WIDTH+1)'(pos_limit(INDEX_WIDTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos         <= '0;
         frame_start <= 1'b1;
      end else if (in_valid) begin
         if (in_last) begin
            pos         <= '0;
            frame_start <= 1'b1;
         end else begin
            frame_start <= 1'b0;
            if (pos != LIMIT) pos <= pos + 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_index_select.sv
// ----------------------------------------------------------------------------
// serial_index_select
//   Returns the element at a requested position of the next complete frame of
//   a serial stream. A request (idx) is accepted in IDLE; the block then waits
//   for a frame boundary, scans that frame one element per cycle and presents
//   the selected element (hit) or 0 (miss, frame shorter than idx+1) until the
//   downstream handshake completes. The stream is never stalled.
//   Ports:
//     clk, rst             : clock, async active-low reset
//     idx_valid/idx_ready  : request handshake, idx = requested position
//     in_valid/in/in_last  : signed element stream, last marks end of frame
//     out_valid/out_ready  : result handshake
//     out                  : selected element, 0 on miss
//     out_hit              : 1 = element found, 0 = frame ended before idx
// ----------------------------------------------------------------------------
module serial_index_select
   import serial_index_select_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   idx_valid,
   output logic                   idx_ready,
   input  logic [INDEX_WIDTH-1:0] idx,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out,
   output logic                   out_hit
);

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [INDEX_WIDTH-1:0] sel_idx;
   logic [INDEX_WIDTH:0]   pos;
   logic                   frame_start;
   logic                   at_start;
   logic                   match;
   logic                   eval;

   serial_frame_position #(.INDEX_WIDTH(INDEX_WIDTH)) u_pos (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .pos         (pos),
      .frame_start (frame_start)
   );

   // Element 0 of a frame: counter at 0 with the frame_start flag set.
   assign at_start = in_valid && frame_start && (pos == '0);
   // Saturated positions carry the extra MSB and therefore never match.
   assign match    = (pos == {1'b0, sel_idx});
   // The element under evaluation this cycle; ARM evaluates element 0 in the
   // same cycle it detects the boundary so no element of the frame is lost.
   assign eval     = in_valid && ((state == ST_SCAN) || ((state == ST_ARM) && at_start));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (idx_valid) state_nxt = ST_ARM;
         ST_ARM,
         ST_SCAN: if (eval) state_nxt = (match || in_last) ? ST_HOLD : ST_SCAN;
         ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      idx_ready = (state == ST_IDLE);
      out_valid = (state == ST_HOLD);
   end

   // Request index and result registers. A match takes priority over in_last,
   // so a match on the final element reports a hit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_idx <= '0;
         out     <= '0;
         out_hit <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && idx_valid) sel_idx <= idx;
         if (eval) begin
            if (match) begin
               out     <= in;
               out_hit <= 1'b1;
            end else if (in_last) begin
               out     <= '0;
               out_hit <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_index_select.sv
module tb_serial_index_select;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       idx_valid = 1'b0;
   logic       idx_ready;
   logic [2:0] idx = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in = '0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out;
   logic       out_hit;

   int checks = 0;
   int errors = 0;
   // Model of the stream: 1 when the next valid element opens a frame.
   bit at_boundary = 1'b1;

   serial_index_select #(.WIDTH(8), .INDEX_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
      .in_valid(in_valid), .in(in), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_hit(out_hit)
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus; returns 1 time unit after the edge.
   task automatic drive(input bit v, input logic [7:0] d, input bit l,
                        input bit iv, input logic [2:0] ix, input bit ordy);
      in_valid = v; in = d; in_last = l; idx_valid = iv; idx = ix; out_ready = ordy;
      @(posedge clk); #1;
      if (v) at_boundary = l;
      in_valid = 1'b0; in_last = 1'b0; idx_valid = 1'b0; out_ready = 1'b0;
   endtask

   // One request against one freshly generated frame. The expected result is
   // derived from the frame contents: element ridx if the frame is long
   // enough, otherwise a miss decided by the last element.
   task automatic scan_test(input string name, input int ridx, input int flen,
                            input bit acc_elem, input bit acc_last, input int ready_wait,
                            input bit use_force, input logic [7:0] fval);
      logic [7:0] fr[$];
      logic [7:0] exp_out;
      logic [2:0] ridx3;
      bit exp_hit;
      bit done;
      int decisive;
      for (int i = 0; i < flen; i++) fr.push_back(8'($urandom));
      if (use_force && ridx < flen) fr[ridx] = fval;
      exp_hit  = (ridx < flen);
      exp_out  = exp_hit ? fr[ridx] : 8'h00;
      decisive = exp_hit ? ridx : flen - 1;
      ridx3    = 3'(ridx);

      checks++;
      if (idx_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: idx_ready=%b out_valid=%b required 1 0", name, idx_ready, out_valid);
      end
      // Acceptance cycle; its element (if any) is never scanned.
      drive(acc_elem, 8'($urandom), acc_last, 1'b1, ridx3, 1'b0);
      checks++;
      if (idx_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: idx_ready=%b required 0", name, idx_ready);
      end
      // Finish the frame in progress; none of it may produce a result.
      if (!at_boundary) begin
         int n;
         n = $urandom_range(0, 3);
         for (int k = 0; k <= n; k++) begin
            drive(1'b1, 8'($urandom), k == n, 1'($urandom), 3'($urandom), 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s preframe: out_valid=%b required 0", name, out_valid);
            end
         end
      end
      done = 1'b0;
      for (int i = 0; i < flen; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 8'($urandom), 1'b0, 1'($urandom), 3'($urandom), 1'b0);
            checks++;
            if (out_valid !== done) begin
               errors++;
               $display("FAIL %s gap%0d: out_valid=%b required %b", name, i, out_valid, done);
            end
         end
         drive(1'b1, fr[i], i == flen - 1, 1'($urandom), 3'($urandom), 1'b0);
         if (i == decisive) done = 1'b1;
         checks++;
         if (out_valid !== done) begin
            errors++;
            $display("FAIL %s elem%0d: out_valid=%b required %b", name, i, out_valid, done);
         end
         if (done) begin
            checks++;
            if (out !== exp_out || out_hit !== exp_hit || idx_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s result%0d: out=%0d hit=%b idx_ready=%b required out=%0d hit=%b idx_ready=0",
                        name, i, $signed(out), out_hit, idx_ready, $signed(exp_out), exp_hit);
            end
         end
      end
      // Backpressure: result must stay put while the stream keeps moving.
      for (int w = 0; w < ready_wait; w++) begin
         drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out !== exp_out || out_hit !== exp_hit || idx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s hold%0d: out_valid=%b out=%0d hit=%b idx_ready=%b required 1 %0d %b 0",
                     name, w, out_valid, $signed(out), out_hit, idx_ready, $signed(exp_out), exp_hit);
         end
      end
      drive(1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 3'($urandom), 1'b1);
      checks++;
      if (out_valid !== 1'b0 || idx_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s handshake: out_valid=%b idx_ready=%b required 0 1", name, out_valid, idx_ready);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (idx_ready !== 1'b1 || out_valid !== 1'b0 || out !== 8'h00 || out_hit !== 1'b0) begin
         errors++;
         $display("FAIL reset: idx_ready=%b out_valid=%b out=%0d hit=%b required 1 0 0 0",
                  idx_ready, out_valid, out, out_hit);
      end
      #2 rst = 1'b1;
      at_boundary = 1'b1;
   endtask

   task automatic test_basic_hit();
      scan_test("basic_hit", 3, 5, 1'b0, 1'b0, 0, 1'b1, 8'd42);
   endtask

   task automatic test_miss();
      scan_test("miss", 6, 4, 1'b0, 1'b0, 1, 1'b0, 8'h00);
   endtask

   task automatic test_mid_frame();
      // Align, then put two elements of frame A on the stream before asking.
      drive(1'b1, 8'($urandom), 1'b1, 1'b0, 3'd0, 1'b0);
      drive(1'b1, 8'd8, 1'b0, 1'b0, 3'd0, 1'b0);
      drive(1'b1, 8'hF7, 1'b0, 1'b0, 3'd0, 1'b0);
      checks++;
      if (idx_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_frame pre: idx_ready=%b out_valid=%b required 1 0", idx_ready, out_valid);
      end
      scan_test("mid_frame", 1, 4, 1'b1, 1'b0, 0, 1'b1, 8'h80);
   endtask

   task automatic test_last_in_accept();
      scan_test("last_in_accept", 0, 3, 1'b1, 1'b1, 0, 1'b1, 8'h5A);
   endtask

   task automatic test_backpressure();
      scan_test("backpressure", 2, 6, 1'b0, 1'b0, 5, 1'b0, 8'h00);
   endtask

   task automatic test_match_on_last();
      scan_test("match_last", 2, 3, 1'b0, 1'b0, 0, 1'b1, 8'd77);
   endtask

   task automatic test_overlong();
      scan_test("overlong_hit", 7, 12, 1'b0, 1'b0, 0, 1'b1, 8'hFD);
      scan_test("overlong_miss", 7, 7, 1'b0, 1'b0, 0, 1'b0, 8'h00);
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'($urandom), 1'b1, 1'b0, 3'd0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0);
      drive(1'b1, 8'd11, 1'b0, 1'b0, 3'd0, 1'b0);
      drive(1'b1, 8'd12, 1'b0, 1'b0, 3'd0, 1'b0);
      checks++;
      if (idx_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset scan: idx_ready=%b out_valid=%b required 0 0", idx_ready, out_valid);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || idx_ready !== 1'b1 || out !== 8'h00 || out_hit !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: out_valid=%b idx_ready=%b out=%0d hit=%b required 0 1 0 0",
                  out_valid, idx_ready, out, out_hit);
      end
      #2 rst = 1'b1;
      at_boundary = 1'b1;
      scan_test("after_reset", 3, 5, 1'b0, 1'b0, 0, 1'b1, 8'd42);
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         scan_test("random", $urandom_range(0, 7), $urandom_range(1, 12),
                   1'($urandom), 1'($urandom), $urandom_range(0, 4), 1'b0, 8'h00);
      end
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_miss();
      test_mid_frame();
      test_last_in_accept();
      test_backpressure();
      test_match_on_last();
      test_overlong();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
